udp_loopback: RTL
=================

UDP_LOOPBACK -- requirements
Module: udp_loopback

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning payload buffer size in bytes (power of two, 16..4096).
REQ-002 SHALL have port clk  input  1  single clock for all logic (UDP rx and tx user sides share it).
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port udp_rx_data_vld  input  1  received payload byte valid.
REQ-005 SHALL have port udp_rx_data  input  8  received payload byte.
REQ-006 SHALL have port udp_rx_done  input  1  one-cycle pulse, end of received datagram.
REQ-007 SHALL have port udp_rx_data_num  input  16  received payload length (informational only).
REQ-008 SHALL have port tx_rdy  input  1  Ethernet transmitter idle.
REQ-009 SHALL have port udp_tx_req  input  1  transmitter requests next payload byte.
REQ-010 SHALL have port udp_tx_en  output  1  one-cycle pulse starting a UDP transmit.
REQ-011 SHALL have port udp_tx_data  output  8  payload byte, valid one cycle after udp_tx_req.
REQ-012 SHALL have port udp_tx_data_num  output  16  payload byte count of the transmit.
REQ-013 SHALL have port drop_cnt  output  16  count of datagrams discarded.

Function
REQ-014 SHALL echo each received UDP payload back unchanged as one UDP transmit.
REQ-015 SHALL implement states IDLE, RX, WAIT_RDY, TX, with IDLE after reset.
REQ-016 IDLE: first udp_rx_data_vld -> RX; byte written at address 0, write count = 1.
REQ-017 RX: each vld byte written at address = write count, count incremented; bytes beyond DEPTH discarded, count saturating at DEPTH.
REQ-018 RX: udp_rx_done -> WAIT_RDY, udp_tx_data_num latched = write count (zero-extended to 16 bits); vld and done in the same cycle stores the byte first.
REQ-019 IDLE: udp_rx_done with no preceding vld byte (zero-length datagram) SHALL be ignored, state unchanged.
REQ-020 WAIT_RDY: while tx_rdy = 1, assert udp_tx_en for exactly one cycle, clear read address, -> TX on the next cycle.
REQ-021 TX: each udp_tx_req cycle reads the buffer at the read address, presents the byte on udp_tx_data next cycle, increments the read address.
REQ-022 TX: the cycle after the udp_tx_data_num-th request is served -> IDLE; further requests SHALL return 8'h00 and SHALL NOT move the read address.
REQ-023 Any udp_rx_data_vld in WAIT_RDY or TX SHALL NOT write the buffer; that datagram is dropped, drop_cnt increments once at its udp_rx_done.
REQ-024 drop_cnt SHALL saturate at 16'hFFFF.
REQ-025 udp_tx_data SHALL hold its last value when no request is served.
REQ-026 Buffer SHALL be a single simple-dual-port RAM of DEPTH x 8 with registered read.

Reset
REQ-027 rst SHALL asynchronously force state IDLE, udp_tx_en = 0, udp_tx_data = 8'h00, udp_tx_data_num = 16'd0, drop_cnt = 16'd0, write count and read address = 0.
REQ-028 Reset during RX, WAIT_RDY or TX SHALL discard the buffered datagram; no udp_tx_en after release until a new datagram completes.
REQ-029 RAM contents need not be cleared by reset.

Configuration
REQ-030 With macro UDP_LOOPBACK_DROP_CNT_EN defined, drop_cnt SHALL behave per REQ-023/024.
REQ-031 Without UDP_LOOPBACK_DROP_CNT_EN, drop_cnt SHALL be tied to 16'd0 with no counter logic; all other behaviour identical.

Verification
REQ-032 Bytes 01..0A with vld, then done, tx_rdy = 1 -> one udp_tx_en pulse, udp_tx_data_num = 10, 10 reqs return 01..0A each one cycle after its req.
REQ-033 DEPTH = 16, 20-byte datagram -> udp_tx_data_num = 16, first 16 bytes echoed, 17th req returns 8'h00.
REQ-034 tx_rdy held 0 for 50 cycles after done -> udp_tx_en stays 0, pulses once in the first cycle tx_rdy = 1.
REQ-035 Second 4-byte datagram arriving during TX of the first -> first echoed intact, second not echoed, drop_cnt = 1 (0 without UDP_LOOPBACK_DROP_CNT_EN).
REQ-036 rst pulsed mid-TX after 3 of 8 reqs -> outputs at reset values, state IDLE, no udp_tx_en until a new datagram completes.
REQ-037 udp_rx_done pulse with no vld bytes in IDLE -> no udp_tx_en, drop_cnt unchanged.

Source files
------------

// File: rtl/udp_loopback.sv
// UDP payload echo: buffers one received datagram in a DEPTH x 8 RAM and replays it as one transmit.
// Optional drop counter for datagrams that arrive while busy: define UDP_LOOPBACK_DROP_CNT_EN.
module udp_loopback #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_rx_data_vld,
  input  logic [7:0]  udp_rx_data,
  input  logic        udp_rx_done,
  input  logic [15:0] udp_rx_data_num,
  input  logic        tx_rdy,
  input  logic        udp_tx_req,
  output logic        udp_tx_en,
  output logic [7:0]  udp_tx_data,
  output logic [15:0] udp_tx_data_num,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RX       = 2'd1;
  localparam logic [1:0] S_WAIT_RDY = 2'd2;
  localparam logic [1:0] S_TX       = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wcnt;
  logic [CW-1:0] r_raddr;
  logic          r_drop_pend;
  logic          r_zero;
  logic [7:0]    r_ram_q;
  logic [7:0]    r_mem [DEPTH];

  logic          w_rx_accept;
  logic          w_wr_en;
  logic [CW-1:0] w_wcnt_next;
  logic          w_busy;
  logic          w_drop_byte;
  logic          w_drop_done;
  logic          w_rd_en;
  logic          w_last;
  logic          w_unused;

  // Receive length is recomputed from the byte stream; the reported length is not trusted.
  assign w_unused = ^udp_rx_data_num;

  assign w_rx_accept = udp_rx_data_vld &&
                       ((r_state == S_IDLE && !r_drop_pend) || r_state == S_RX);
  assign w_wr_en     = w_rx_accept && (r_wcnt < C_DEPTH);
  assign w_wcnt_next = w_wr_en ? r_wcnt + CW'(1) : r_wcnt;

  // A datagram seen while busy is swallowed until its done pulse, even if that lands back in IDLE.
  assign w_busy      = (r_state == S_WAIT_RDY) || (r_state == S_TX);
  assign w_drop_byte = udp_rx_data_vld && (w_busy || (r_state == S_IDLE && r_drop_pend));
  assign w_drop_done = udp_rx_done && (r_drop_pend || w_drop_byte);

  assign w_rd_en = (r_state == S_TX) && udp_tx_req && (16'(r_raddr) < udp_tx_data_num);
  assign w_last  = w_rd_en && ((16'(r_raddr) + 16'd1) == udp_tx_data_num);

  assign udp_tx_en   = (r_state == S_WAIT_RDY) && tx_rdy;
  assign udp_tx_data = r_zero ? 8'h00 : r_ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wcnt          <= '0;
      r_raddr         <= '0;
      udp_tx_data_num <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_accept) begin
            if (udp_rx_done) begin
              r_state         <= S_WAIT_RDY;
              udp_tx_data_num <= 16'(w_wcnt_next);
              r_wcnt          <= '0;
            end else begin
              r_state <= S_RX;
              r_wcnt  <= w_wcnt_next;
            end
          end
        end
        S_RX: begin
          if (udp_rx_done) begin
            r_state         <= S_WAIT_RDY;
            udp_tx_data_num <= 16'(w_wcnt_next);
            r_wcnt          <= '0;
          end else begin
            r_wcnt <= w_wcnt_next;
          end
        end
        S_WAIT_RDY: begin
          if (tx_rdy) begin
            r_state <= S_TX;
            r_raddr <= '0;
          end
        end
        default: begin
          if (w_rd_en) r_raddr <= r_raddr + CW'(1);
          if (w_last)  r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Unserved requests read as zero; the output otherwise holds the last served byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_pend <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      if (w_drop_done)      r_drop_pend <= 1'b0;
      else if (w_drop_byte) r_drop_pend <= 1'b1;
      if (w_rd_en)          r_zero <= 1'b0;
      else if (udp_tx_req)  r_zero <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wcnt[AW-1:0]] <= udp_rx_data;
    if (w_rd_en) r_ram_q <= r_mem[r_raddr[AW-1:0]];
  end

`ifdef UDP_LOOPBACK_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_drop_cnt <= 16'd0;
    else if (w_drop_done && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
